// File: rtl/rdyack_burst_repeat.sv
// Expands one (base, count) rdy/ack descriptor into `count` registered output beats.
// Optional macro BURST_REPEAT_STRIDE_EN adds a per-descriptor index stride (default stride 1).
module rdyack_burst_repeat #(
  parameter int unsigned BW_CNT = 8,
  parameter int unsigned BW_IDX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              src_rdy,
  output logic              src_ack,
  input  logic [BW_IDX-1:0] i_base,
  input  logic [BW_CNT-1:0] i_cnt,
`ifdef BURST_REPEAT_STRIDE_EN
  input  logic [BW_IDX-1:0] i_stride,
`endif
  output logic              dst_rdy,
  input  logic              dst_ack,
  output logic [BW_IDX-1:0] o_idx,
  output logic              o_last,
  output logic              o_busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [BW_CNT-1:0] rem_q;
  logic [BW_IDX-1:0] step;
  logic              beat_done;
  logic              last_done;

  // Remaining beats after the one currently presented on o_idx.
`ifdef BURST_REPEAT_STRIDE_EN
  logic [BW_IDX-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = BW_IDX'(1);
`endif

  assign beat_done = (state_q == StRun) && dst_ack;
  assign last_done = beat_done && o_last;

  // A new descriptor may be taken while the final beat of the previous burst is consumed.
  assign src_ack = src_rdy && ((state_q == StIdle) || last_done);
  assign o_busy  = dst_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      dst_rdy  <= 1'b0;
      o_idx    <= '0;
      o_last   <= 1'b0;
      rem_q    <= '0;
`ifdef BURST_REPEAT_STRIDE_EN
      stride_q <= '0;
`endif
    end else if (src_ack) begin
`ifdef BURST_REPEAT_STRIDE_EN
      stride_q <= i_stride;
`endif
      if (i_cnt != '0) begin
        state_q <= StRun;
        dst_rdy <= 1'b1;
        o_idx   <= i_base;
        rem_q   <= i_cnt - BW_CNT'(1);
        o_last  <= (i_cnt == BW_CNT'(1));
      end else begin
        // Zero-length descriptor is consumed without producing a beat.
        state_q <= StIdle;
        dst_rdy <= 1'b0;
        o_last  <= 1'b0;
        rem_q   <= '0;
      end
    end else if (beat_done) begin
      if (o_last) begin
        state_q <= StIdle;
        dst_rdy <= 1'b0;
        o_last  <= 1'b0;
      end else begin
        o_idx  <= o_idx + step;
        rem_q  <= rem_q - BW_CNT'(1);
        o_last <= (rem_q == BW_CNT'(1));
      end
    end
  end

endmodule
